wb_initiator: RTL and testbench
===============================

WB_INITIATOR -- requirements
Module: wb_initiator

Interface
REQ-001 SHALL have parameter dw, default 32: Wishbone data width.
REQ-002 SHALL have parameter aw, default 32: Wishbone address width.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum wait cycles per bus attempt, range 1..255.
REQ-004 SHALL have parameter MAX_RETRY, default 3: maximum re-issues after wb_rty_i, range 0..15.
REQ-005 SHALL have parameter RETRY_DELAY, default 4: idle cycles between retry attempts, range 1..255.
REQ-006 SHALL have port wb_clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port wb_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-008 SHALL have port cmd_valid, input, 1: command request.
REQ-009 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid is also high.
REQ-010 SHALL have port cmd_we, input, 1: 1 = write, 0 = read.
REQ-011 SHALL have ports cmd_adr, input, aw; cmd_dat, input, dw; cmd_sel, input, 4: command fields.
REQ-012 SHALL have port rsp_valid, output, 1: response available.
REQ-013 SHALL have port rsp_ready, input, 1: response consumed.
REQ-014 SHALL have port rsp_dat, output, dw: read data.
REQ-015 SHALL have port rsp_status, output, 2: 00 OK, 01 ERR, 10 TIMEOUT, 11 RETRY_EXHAUSTED.
REQ-016 SHALL have ports wb_cyc_o, wb_stb_o, wb_we_o, output, 1 each; wb_adr_o, output, aw; wb_dat_o, output, dw; wb_sel_o, output, 4: Wishbone master outputs.
REQ-017 SHALL have ports wb_dat_i, input, dw; wb_ack_i, wb_err_i, wb_rty_i, input, 1 each: Wishbone master inputs.

Function
REQ-018 SHALL implement FSM states IDLE, BUS, BACKOFF and RESP; all outputs SHALL be registered.
REQ-019 SHALL drive cmd_ready high only in IDLE; on cmd_valid&cmd_ready, SHALL latch the command fields, clear the retry and timeout counters, and enter BUS, with wb_cyc_o=wb_stb_o=1 on the next cycle.
REQ-020 SHALL hold wb_we_o, wb_adr_o, wb_dat_o and wb_sel_o stable from acceptance through BUS and BACKOFF; outside these states they SHALL hold the last command values.
REQ-021 In BUS, SHALL sample the terminations each cycle with priority err > ack > rty; a termination SHALL deassert wb_cyc_o/wb_stb_o on the next edge.
REQ-022 On ack, SHALL enter RESP with status 00; rsp_dat SHALL be wb_dat_i for a read and 0 for a write.
REQ-023 On err, SHALL enter RESP with status 01 and rsp_dat=0.
REQ-024 On rty with retry_cnt<MAX_RETRY, SHALL increment retry_cnt and enter BACKOFF, keeping cyc/stb low for exactly RETRY_DELAY cycles, then SHALL re-enter BUS and clear the timeout counter.
REQ-025 On rty with retry_cnt==MAX_RETRY, SHALL enter RESP with status 11; when MAX_RETRY=0, the first rty SHALL end the command.
REQ-026 SHALL count the cycles cyc/stb are high in BUS; if the count reaches TIMEOUT with no termination, SHALL drop cyc/stb and enter RESP with status 10.
REQ-027 A termination arriving on the same cycle the timeout is reached SHALL win over the timeout.
REQ-028 In RESP, SHALL hold rsp_valid=1 and rsp_dat/rsp_status stable until rsp_ready=1, then return to IDLE; cmd_ready SHALL rise on the following cycle.
REQ-029 SHALL ignore wb_ack_i, wb_err_i and wb_rty_i outside BUS.
REQ-030 SHALL issue at most one outstanding command; there SHALL be no pipelining or bursts.

Reset
REQ-031 While wb_rst_n=0, SHALL force state IDLE, cmd_ready=0 and all Wishbone outputs to 0, with rsp_valid=0, rsp_dat=0, rsp_status=00 and counters 0; cmd_ready=1 SHALL follow on the first clock after release.
REQ-032 Reset asserted mid-BUS or mid-BACKOFF SHALL drop wb_cyc_o/wb_stb_o immediately (asynchronously) and discard the command without a response.

Verification
REQ-033 Read: cmd adr=0x04, we=0; slave acks 2 cycles after stb with dat=0x0000_0C0B -> rsp_valid, rsp_dat=0x0000_0C0B, status 00.
REQ-034 Write: cmd adr=0x08, dat=0xA5A5_00FF, sel=0001; ack -> wb_dat_o/wb_sel_o stable until ack, rsp_dat=0, status 00.
REQ-035 Retry: slave answers rty twice, then ack (MAX_RETRY=3, RETRY_DELAY=4) -> three stb pulses, each gap exactly 4 cycles, status 00; with four rty responses -> status 11.
REQ-036 Error/timeout: err on the first cycle -> status 01; no termination for 255 cycles -> cyc drops, status 10; ack on cycle 255 -> status 00.
REQ-037 Backpressure and reset: rsp_ready held 0 for 10 cycles -> outputs stable and cmd_ready=0; wb_rst_n pulsed low mid-BUS -> cyc/stb=0 at once, no rsp_valid, next command processed normally.

Source files
------------

// File: rtl/wb_initiator.sv
// rtl/wb_initiator.sv - Single-outstanding Wishbone master with retry, backoff and timeout
module wb_initiator #(
    parameter int dw          = 32,
    parameter int aw          = 32,
    parameter int TIMEOUT     = 255,
    parameter int MAX_RETRY   = 3,
    parameter int RETRY_DELAY = 4
) (
    input  logic          wb_clk,
    input  logic          wb_rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [aw-1:0] cmd_adr,
    input  logic [dw-1:0] cmd_dat,
    input  logic [3:0]    cmd_sel,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [dw-1:0] rsp_dat,
    output logic [1:0]    rsp_status,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i,
    input  logic          wb_rty_i
);

    typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} state_t;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_ERR  = 2'b01;
    localparam logic [1:0] ST_TMO  = 2'b10;
    localparam logic [1:0] ST_RTYX = 2'b11;

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_retry_cnt, w_retry_nxt;
    logic [7:0]    r_tmo_cnt, w_tmo_nxt;
    logic [7:0]    r_bo_cnt, w_bo_nxt;
    logic [8:0]    w_tmo_inc;
    logic          w_accept;
    logic          w_cyc_nxt;
    logic          w_rsp_valid_nxt;
    logic [dw-1:0] w_rsp_dat_nxt;
    logic [1:0]    w_rsp_status_nxt;

    assign w_tmo_inc = {1'b0, r_tmo_cnt} + 9'd1;

    always_comb begin
        w_state_nxt      = r_state;
        w_retry_nxt      = r_retry_cnt;
        w_tmo_nxt        = r_tmo_cnt;
        w_bo_nxt         = r_bo_cnt;
        w_accept         = 1'b0;
        w_cyc_nxt        = wb_cyc_o;
        w_rsp_valid_nxt  = rsp_valid;
        w_rsp_dat_nxt    = rsp_dat;
        w_rsp_status_nxt = rsp_status;
        case (r_state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = BUS;
                    w_retry_nxt = '0;
                    w_tmo_nxt   = '0;
                    w_cyc_nxt   = 1'b1;
                end
            end
            BUS: begin
                // Terminations are checked before the timeout so a late reply still wins.
                if (wb_err_i) begin
                    w_state_nxt      = RESP;
                    w_cyc_nxt        = 1'b0;
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_dat_nxt    = '0;
                    w_rsp_status_nxt = ST_ERR;
                end else if (wb_ack_i) begin
                    w_state_nxt      = RESP;
                    w_cyc_nxt        = 1'b0;
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_dat_nxt    = wb_we_o ? '0 : wb_dat_i;
                    w_rsp_status_nxt = ST_OK;
                end else if (wb_rty_i) begin
                    w_cyc_nxt = 1'b0;
                    if (r_retry_cnt == 4'(MAX_RETRY)) begin
                        w_state_nxt      = RESP;
                        w_rsp_valid_nxt  = 1'b1;
                        w_rsp_dat_nxt    = '0;
                        w_rsp_status_nxt = ST_RTYX;
                    end else begin
                        w_state_nxt = BACKOFF;
                        w_retry_nxt = r_retry_cnt + 4'd1;
                        w_bo_nxt    = '0;
                    end
                end else if (w_tmo_inc == 9'(TIMEOUT)) begin
                    w_state_nxt      = RESP;
                    w_cyc_nxt        = 1'b0;
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_dat_nxt    = '0;
                    w_rsp_status_nxt = ST_TMO;
                end else begin
                    w_tmo_nxt = w_tmo_inc[7:0];
                end
            end
            BACKOFF: begin
                if (r_bo_cnt == 8'(RETRY_DELAY - 1)) begin
                    w_state_nxt = BUS;
                    w_cyc_nxt   = 1'b1;
                    w_tmo_nxt   = '0;
                end else begin
                    w_bo_nxt = r_bo_cnt + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt     = IDLE;
                    w_rsp_valid_nxt = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state     <= IDLE;
            r_retry_cnt <= '0;
            r_tmo_cnt   <= '0;
            r_bo_cnt    <= '0;
            cmd_ready   <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_sel_o    <= '0;
            rsp_valid   <= 1'b0;
            rsp_dat     <= '0;
            rsp_status  <= ST_OK;
        end else begin
            r_state     <= w_state_nxt;
            r_retry_cnt <= w_retry_nxt;
            r_tmo_cnt   <= w_tmo_nxt;
            r_bo_cnt    <= w_bo_nxt;
            cmd_ready   <= (w_state_nxt == IDLE);
            wb_cyc_o    <= w_cyc_nxt;
            wb_stb_o    <= w_cyc_nxt;
            rsp_valid   <= w_rsp_valid_nxt;
            rsp_dat     <= w_rsp_dat_nxt;
            rsp_status  <= w_rsp_status_nxt;
            if (w_accept) begin
                wb_we_o  <= cmd_we;
                wb_adr_o <= cmd_adr;
                wb_dat_o <= cmd_dat;
                wb_sel_o <= cmd_sel;
            end
        end
    end

endmodule

// File: tb/tb_wb_initiator.sv
// tb/tb_wb_initiator.sv - Randomized bench for wb_initiator against a transaction-level model
module tb_wb_initiator;

    localparam int TMO = 255;
    localparam int MR  = 3;
    localparam int RD  = 4;

    logic        wb_clk;
    logic        wb_rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_status;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;

    int n_cmp = 0;
    int n_mis = 0;

    wb_initiator #(
        .dw(32), .aw(32), .TIMEOUT(TMO), .MAX_RETRY(MR), .RETRY_DELAY(RD)
    ) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_status(rsp_status),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // fin_kind: 0 ack, 1 err, 2 silent slave; delays count stb-high cycles before the reply
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int n_rty, input int fin_kind,
                           input int fin_delay, input logic [31:0] rdata, input int rdy_wait);
        int rdly[8];
        int exp_pulses, exp_len, exp_status;
        logic [31:0] exp_dat;
        int pulses, stb_cnt, gap, last_len, cyc_cnt, k, att, kind, dly;
        bit done;
        for (int i = 0; i < 8; i++) rdly[i] = $urandom_range(0, 3);

        if (n_rty > MR) begin
            exp_pulses = MR + 1; exp_status = 3; exp_dat = 0; exp_len = rdly[MR] + 1;
        end else begin
            exp_pulses = n_rty + 1;
            if (fin_kind == 2 || fin_delay + 1 > TMO) begin
                exp_status = 2; exp_dat = 0; exp_len = TMO;
            end else if (fin_kind == 1) begin
                exp_status = 1; exp_dat = 0; exp_len = fin_delay + 1;
            end else begin
                exp_status = 0; exp_dat = we ? 32'h0 : rdata; exp_len = fin_delay + 1;
            end
        end

        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge wb_clk);
            k++;
        end
        if (!cmd_ready) begin
            chk("cmd_accept", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        @(negedge wb_clk);
        cmd_valid = 1'b0;
        cmd_we = $urandom; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
        chk("cyc_on_accept", wb_cyc_o, 1);
        chk("ready_low_busy", cmd_ready, 0);

        pulses = 0; stb_cnt = 0; gap = 0; last_len = 0; cyc_cnt = 0; done = 0;
        while (!done && cyc_cnt < 3000) begin
            wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_dat_i = $urandom;
            if (wb_cyc_o) begin
                if (stb_cnt == 0) begin
                    if (pulses > 0) chk("retry_gap", gap, RD);
                    pulses++;
                    gap = 0;
                end
                stb_cnt++;
                chk("stb_eq_cyc", wb_stb_o, 1);
                chk("we_stable", wb_we_o, we);
                chk("adr_stable", wb_adr_o, adr);
                chk("dat_stable", wb_dat_o, dat);
                chk("sel_stable", wb_sel_o, sel);
                chk("no_rsp_in_bus", rsp_valid, 0);
                att = (pulses - 1 > 7) ? 7 : pulses - 1;
                if (att < n_rty) begin kind = 3; dly = rdly[att]; end
                else begin kind = fin_kind; dly = fin_delay; end
                if (stb_cnt == dly + 1) begin
                    case (kind)
                        0: begin wb_ack_i = 1; wb_dat_i = rdata; end
                        1: wb_err_i = 1;
                        3: wb_rty_i = 1;
                        default: ;
                    endcase
                end
            end else begin
                if (stb_cnt > 0) begin last_len = stb_cnt; stb_cnt = 0; end
                if (rsp_valid) done = 1;
                else begin
                    if (pulses > 0) gap++;
                    {wb_ack_i, wb_err_i, wb_rty_i} = 3'($urandom);
                end
            end
            if (!done) begin
                @(negedge wb_clk);
                cyc_cnt++;
            end
        end
        if (!done) begin
            chk("rsp_budget", 0, 1);
            return;
        end
        chk("pulse_count", pulses, exp_pulses);
        chk("last_pulse_len", last_len, exp_len);

        for (int i = 0; i <= rdy_wait; i++) begin
            chk("rsp_valid_held", rsp_valid, 1);
            chk("rsp_dat", rsp_dat, exp_dat);
            chk("rsp_status", rsp_status, exp_status);
            chk("ready_low_resp", cmd_ready, 0);
            chk("cyc_low_resp", wb_cyc_o, 0);
            chk("adr_held_resp", wb_adr_o, adr);
            {wb_ack_i, wb_err_i, wb_rty_i} = 3'($urandom);
            if (i == rdy_wait) rsp_ready = 1;
            @(negedge wb_clk);
        end
        rsp_ready = 0; wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
        chk("rsp_cleared", rsp_valid, 0);
        chk("ready_after_rsp", cmd_ready, 1);
    endtask

    initial begin
        wb_rst_n = 0; cmd_valid = 0; cmd_we = 0; cmd_adr = 0; cmd_dat = 0; cmd_sel = 0;
        rsp_ready = 0; wb_dat_i = 0; wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0;
        repeat (3) @(negedge wb_clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_cyc", wb_cyc_o, 0);
        chk("rst_stb", wb_stb_o, 0);
        chk("rst_we", wb_we_o, 0);
        chk("rst_adr", wb_adr_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_sel", wb_sel_o, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_dat", rsp_dat, 0);
        chk("rst_rsp_status", rsp_status, 0);
        wb_rst_n = 1;
        #1;
        chk("ready_before_edge", cmd_ready, 0);
        @(negedge wb_clk);
        chk("ready_after_release", cmd_ready, 1);

        run_txn(0, 32'h04, $urandom, 4'hF, 0, 0, 2, 32'h0000_0C0B, 0);
        run_txn(1, 32'h08, 32'hA5A5_00FF, 4'b0001, 0, 0, 1, $urandom, 0);
        run_txn(0, 32'h10, $urandom, 4'hF, 2, 0, 1, 32'h1234_5678, 1);
        run_txn(0, 32'h14, $urandom, 4'hF, 4, 0, 1, 32'hDEAD_BEEF, 0);
        run_txn(1, 32'h18, $urandom, 4'hC, 0, 1, 0, $urandom, 0);
        run_txn(0, 32'h1C, $urandom, 4'hF, 0, 2, 0, $urandom, 0);
        run_txn(0, 32'h20, $urandom, 4'hF, 0, 0, TMO - 1, 32'hCAFE_F00D, 0);
        run_txn(0, 32'h24, $urandom, 4'h3, 0, 0, 3, 32'h0BAD_CAFE, 10);

        cmd_we = 0; cmd_adr = 32'h28; cmd_dat = $urandom; cmd_sel = 4'hF; cmd_valid = 1;
        for (int k = 0; k < 50 && !cmd_ready; k++) @(negedge wb_clk);
        @(negedge wb_clk);
        cmd_valid = 0;
        repeat (5) @(negedge wb_clk);
        chk("cyc_before_rst", wb_cyc_o, 1);
        wb_rst_n = 0;
        #1;
        chk("rst_async_cyc", wb_cyc_o, 0);
        chk("rst_async_stb", wb_stb_o, 0);
        chk("rst_async_rsp", rsp_valid, 0);
        chk("rst_async_ready", cmd_ready, 0);
        repeat (3) @(negedge wb_clk);
        wb_rst_n = 1;
        @(negedge wb_clk);
        chk("rst2_ready", cmd_ready, 1);
        chk("rst2_no_rsp", rsp_valid, 0);
        chk("rst2_cyc", wb_cyc_o, 0);
        run_txn(0, 32'h2C, $urandom, 4'hF, 1, 0, 0, 32'h5555_AAAA, 0);

        for (int t = 0; t < 40; t++) begin
            int kind;
            kind = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
            run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom_range(0, 5),
                    kind, $urandom_range(0, 6), $urandom, $urandom_range(0, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
